// File: rtl/axi_width_pkg.sv
// ---------------------------------------------------------------------------
// axi_width_pkg
// Shared helpers for the AXI W-channel width converters.
//   lane_width() : bits needed to index RATIO lanes (never less than 1)
//   is_pow2()    : power-of-two test
//   params_ok()  : legal parameter set for an upsizer, used at elaboration
// ---------------------------------------------------------------------------
package axi_width_pkg;

  function automatic int lane_width(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int in_width, input int ratio, input int user_width);
    return (in_width > 0) && ((in_width % 8) == 0) &&
           is_pow2(ratio) && (ratio <= 16) && (user_width >= 1);
  endfunction

endpackage

// File: rtl/axi_write_channel_reg.sv
// ---------------------------------------------------------------------------
// axi_write_channel_reg
// Single-entry output register for a W channel. Loads a beat on load_i,
// holds it while the downstream stalls and drains it on ready_i.
//   clock, reset        : clock, asynchronous active-high reset
//   load_i              : capture data_i/strb_i/last_i/user_i this edge
//   ready_i             : downstream ready
//   ready_o             : slot free or draining this cycle
//   valid_o, data_o ... : registered beat towards the downstream
// ---------------------------------------------------------------------------
module axi_write_channel_reg #(
  parameter int DATA_W = 128,
  parameter int STRB_W = 16,
  parameter int USER_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [STRB_W-1:0] strb_i,
  input  logic              last_i,
  input  logic [USER_W-1:0] user_i,
  input  logic              ready_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [STRB_W-1:0] strb_o,
  output logic              last_o,
  output logic [USER_W-1:0] user_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              last_q, last_d;
  logic [USER_W-1:0] user_q, user_d;

  // Depends only on register state and downstream ready, never on upstream inputs.
  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;
    user_d  = user_q;
    if (load_i) begin
      // A load is only issued when ready_o is high, so reloading while
      // draining gives back-to-back beats with no bubble.
      valid_d = 1'b1;
      data_d  = data_i;
      strb_d  = strb_i;
      last_d  = last_i;
      user_d  = user_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign last_o  = last_q;
  assign user_o  = user_q;

endmodule

// File: rtl/axi_write_channel_upsizer.sv
// ---------------------------------------------------------------------------
// axi_write_channel_upsizer
// Packs RATIO narrow W beats into one wide W beat. The first beat of a burst
// lands in lane s_start_lane; a burst closes its wide word early on wlast,
// leaving the unwritten lanes with zero data and zero strobe.
//   clock, reset                      : clock, asynchronous active-high reset
//   s_wdata/wstrb/wlast/wuser/wvalid  : narrow W input, s_wready back
//   s_start_lane                      : lane of the first beat of a burst
//   m_wdata/wstrb/wlast/wuser/wvalid  : wide W output, m_wready in
// ---------------------------------------------------------------------------
module axi_write_channel_upsizer
  import axi_width_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int RATIO      = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [IN_WIDTH-1:0]               s_wdata,
  input  logic [IN_WIDTH/8-1:0]             s_wstrb,
  input  logic                              s_wlast,
  input  logic [USER_WIDTH-1:0]             s_wuser,
  input  logic                              s_wvalid,
  output logic                              s_wready,
  input  logic [lane_width(RATIO)-1:0]      s_start_lane,
  output logic [IN_WIDTH*RATIO-1:0]         m_wdata,
  output logic [IN_WIDTH*RATIO/8-1:0]       m_wstrb,
  output logic                              m_wlast,
  output logic [USER_WIDTH-1:0]             m_wuser,
  output logic                              m_wvalid,
  input  logic                              m_wready
);

  localparam int LANE_W    = lane_width(RATIO);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int IN_STRB   = IN_WIDTH / 8;
  localparam int OUT_STRB  = OUT_WIDTH / 8;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if (!params_ok(IN_WIDTH, RATIO, USER_WIDTH)) begin : g_param_check
    $error("axi_write_channel_upsizer: illegal IN_WIDTH/RATIO/USER_WIDTH");
  end

  logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [OUT_STRB-1:0]  acc_strb_q, acc_strb_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic                 first_beat_q, first_beat_d;

  logic [LANE_W-1:0]    cur_lane;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [OUT_STRB-1:0]  merged_strb;
  logic                 accept;
  logic                 complete;

  assign accept = s_wvalid && s_wready;

  // With a single lane the start lane carries no information, so pin it to 0.
  assign cur_lane = (RATIO == 1) ? '0 : (first_beat_q ? s_start_lane : lane_q);

  assign complete = accept && (s_wlast || (cur_lane == LAST_LANE));

  // Accumulator with the current beat overlaid on its lane.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic hit;
    assign hit = accept && (cur_lane == LANE_W'(gi));
    assign merged_data[gi*IN_WIDTH +: IN_WIDTH] =
      hit ? s_wdata : acc_data_q[gi*IN_WIDTH +: IN_WIDTH];
    assign merged_strb[gi*IN_STRB +: IN_STRB] =
      hit ? s_wstrb : acc_strb_q[gi*IN_STRB +: IN_STRB];
  end

  always_comb begin
    acc_data_d   = acc_data_q;
    acc_strb_d   = acc_strb_q;
    lane_d       = lane_q;
    first_beat_d = first_beat_q;
    if (complete) begin
      // The merged word goes straight to the output register; start clean.
      // After wlast the next beat is a new burst and re-samples s_start_lane.
      acc_data_d   = '0;
      acc_strb_d   = '0;
      lane_d       = '0;
      first_beat_d = s_wlast;
    end else if (accept) begin
      acc_data_d   = merged_data;
      acc_strb_d   = merged_strb;
      lane_d       = cur_lane + LANE_W'(1);
      first_beat_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_data_q   <= '0;
      acc_strb_q   <= '0;
      lane_q       <= '0;
      first_beat_q <= 1'b1;
    end else begin
      acc_data_q   <= acc_data_d;
      acc_strb_q   <= acc_strb_d;
      lane_q       <= lane_d;
      first_beat_q <= first_beat_d;
    end
  end

  axi_write_channel_reg #(
    .DATA_W (OUT_WIDTH),
    .STRB_W (OUT_STRB),
    .USER_W (USER_WIDTH)
  ) u_out_reg (
    .clock   (clock),
    .reset   (reset),
    .load_i  (complete),
    .data_i  (merged_data),
    .strb_i  (merged_strb),
    .last_i  (s_wlast),
    .user_i  (s_wuser),
    .ready_i (m_wready),
    .ready_o (s_wready),
    .valid_o (m_wvalid),
    .data_o  (m_wdata),
    .strb_o  (m_wstrb),
    .last_o  (m_wlast),
    .user_o  (m_wuser)
  );

endmodule

// File: doc/axi_write_channel_upsizer.md
Name: axi_write_channel_upsizer

Overview:
Parametrised AXI write-data (W) channel width converter. It packs RATIO narrow W beats into one wide W beat and honours a per-burst starting lane for unaligned bursts. It closes bursts early on wlast, leaving unfilled lanes with zero strobe. It sits between a narrow W master (stream/DMA engine) and a wide memory-side W slave, and carries the same signal set as the existing W channel interface.

Parameters:
IN_WIDTH, 32, narrow wdata width in bits; a multiple of 8.
RATIO, 4, narrow beats per wide beat; a power of two, 1..16.
USER_WIDTH, 1, wuser width; minimum 1.
(derived) OUT_WIDTH = IN_WIDTH*RATIO; LANE_W = max(1, clog2(RATIO)).

Ports:
clock  in  1  single clock; all logic rising-edge.
reset  in  1  asynchronous, active-high reset.
s_wdata  in  IN_WIDTH  narrow write data.
s_wstrb  in  IN_WIDTH/8  narrow byte strobes.
s_wlast  in  1  last narrow beat of burst.
s_wuser  in  USER_WIDTH  narrow user sideband.
s_wvalid  in  1  narrow beat valid.
s_wready  out  1  narrow beat accepted when valid&ready.
s_start_lane  in  LANE_W  lane of first beat of a burst; sampled only on first beat.
m_wdata  out  OUT_WIDTH  wide write data.
m_wstrb  out  OUT_WIDTH/8  wide strobes.
m_wlast  out  1  last wide beat of burst.
m_wuser  out  USER_WIDTH  wide user sideband.
m_wvalid  out  1  wide beat valid.
m_wready  in  1  wide beat accepted.

Behaviour:
- Reset (async assert, sync release): m_wvalid=0, m_wdata/m_wstrb/m_wuser=0, m_wlast=0. Accumulator data/strb=0, lane=0, first_beat=1. A partial word at reset is discarded.
- s_wready = !m_wvalid || m_wready. It depends on no s_* input. Full throughput whenever m_wready=1.
- Lane select on narrow accept: first_beat ? s_start_lane : lane_q. Write s_wdata/s_wstrb into that lane of the accumulator.
- A beat completes the word when lane==RATIO-1 or s_wlast=1.
- On the completing accept, the next cycle shows m_wvalid=1 with:
  - m_wdata/m_wstrb = accumulator merged with the current beat; unwritten lanes have data 0 and strb 0.
  - m_wlast = s_wlast of the completing beat.
  - m_wuser = s_wuser of the completing beat.
- Same edge as the completing accept: accumulator cleared to 0.
  - Lane becomes 0 if wrapped without wlast.
  - Lane becomes don't-care with first_beat=1 if wlast.
- Non-completing accept: lane_q = lane+1; first_beat=0.
- Latency: exactly 1 cycle from the completing narrow accept to m_wvalid.
- Output hold: while m_wvalid=1 and m_wready=0, all m_* signals are stable and s_wready=0.
- Simultaneous m_wready=1 with a completing accept: the output register reloads with the new word, so m_wvalid stays 1 with no bubble.
- m_wvalid clears on m_wready=1 with no new completion.
- RATIO=1: degenerates to a one-stage register slice; s_start_lane ignored.
- Only the low LANE_W bits of s_start_lane are used. s_start_lane on a non-first beat is ignored.
- wlast on the first beat produces a single wide beat with only that lane strobed.
- Narrow beats with s_wstrb=0 still occupy their lane.
- No burst-length checking. A missing wlast simply keeps packing.

Decomposition:
- Package axi_width_pkg holds:
  - lane-index width function (max(1, clog2)).
  - elaboration-time parameter checks (power-of-two RATIO, byte-multiple IN_WIDTH, USER_WIDTH≥1).
- Sub-module axi_write_channel_reg: parametrised single-entry output register. It handles valid/ready hold, load and drain for the m_* side; the accumulator and lane FSM stay in the top.

Test Plan:
1. IN=32, RATIO=4, start_lane 0; send 0x11111111..0x44444444, strb 0xF, wlast on beat 4 -> one m beat, 1 cycle after beat 4. m_wdata=0x44444444_33333333_22222222_11111111, m_wstrb=0xFFFF, m_wlast=1.
2. start_lane=2; send A=0xAAAAAAAA, B=0xBBBBBBBB, C=0xCCCCCCCC, wlast on C -> beat1 data {B,A,0,0}, strb 0xFF00, wlast 0. Beat2 data {0,0,0,C}, strb 0x000F, wlast 1.
3. start_lane=3; single beat 0xDEADBEEF with wlast, wuser=1 -> m_wdata=0xDEADBEEF_00000000_00000000_00000000, m_wstrb=0xF000, m_wlast=1, m_wuser=1.
4. Output valid; hold m_wready=0 for 5 cycles while s_wvalid=1 -> s_wready=0 throughout, m_* stable. Release m_wready -> same word accepted once; packing resumes with no loss or duplication.
5. Assert reset after 2 narrow beats accepted -> m_wvalid=0 immediately (async). Next burst with start_lane=1 packs from lane 1; no stale data/strb appear.
6. RATIO=1; 8 back-to-back beats with m_wready=1 -> each appears 1 cycle later, identical data/strb/last/user. s_wready stays 1 (full throughput).
